// File: rtl/prism_axi_pkg.sv
// Shared types and helpers for the prism AXI write-data controller.
package prism_axi_pkg;

  typedef enum logic [1:0] {IDLE, WAIT_BURST, DATA} state_t;

  localparam int MAX_STRB_WIDTH = 128;

  function automatic int offset_width(input int strb_w);
    return $clog2(strb_w);
  endfunction

  // Byte-enable mask: head bytes below first_off and tail bytes above last_off are cleared.
  function automatic logic [MAX_STRB_WIDTH-1:0] strb_mask(input int strb_w, input int first_off,
                                                          input int last_off, input logic use_first,
                                                          input logic use_last);
    logic [MAX_STRB_WIDTH-1:0] m;
    for (int i = 0; i < MAX_STRB_WIDTH; i++)
      m[i] = (i < strb_w) && !(use_first && i < first_off) && !(use_last && i > last_off);
    return m;
  endfunction

endpackage

// File: rtl/prism_axi_skid_buffer.sv
// Two-entry skid buffer with registered outputs; in_ready depends only on occupancy.
module prism_axi_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;

  assign in_ready = !skid_valid;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (!out_valid || out_ready) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_data   <= skid_data;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= in_valid;
        if (in_valid) out_data <= in_data;
      end
    end else if (in_valid && !skid_valid) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
    end
  end

endmodule

// File: rtl/prism_axi_wdata_ctrl.sv
// AXI W-channel controller: per-burst WSTRB/WLAST generation from a command and AW descriptors.
// Define PRISM_AXI_WDATA_SKID_EN to register the W outputs through a skid buffer.
module prism_axi_wdata_ctrl
  import prism_axi_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int LENGTH_WIDTH   = 16,
  localparam int STRB_WIDTH    = AXI_DATA_WIDTH / 8
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic                      i_cmd_valid,
  output logic                      o_cmd_ready,
  input  logic [AXI_ADDR_WIDTH-1:0] i_cmd_address,
  input  logic [LENGTH_WIDTH-1:0]   i_cmd_length,
  input  logic                      i_burst_valid,
  output logic                      o_burst_ready,
  input  logic [7:0]                i_burst_axlen,
  input  logic                      i_burst_is_last,
  input  logic [AXI_DATA_WIDTH-1:0] s_data,
  input  logic                      s_valid,
  output logic                      s_ready,
  output logic [AXI_DATA_WIDTH-1:0] m_wdata,
  output logic [STRB_WIDTH-1:0]     m_wstrb,
  output logic                      m_wlast,
  output logic                      m_wvalid,
  input  logic                      m_wready,
  output logic                      o_done
);

  localparam int OFFSET_WIDTH = offset_width(STRB_WIDTH);

  state_t                    state, state_nxt;
  logic [OFFSET_WIDTH-1:0]   first_off, last_off;
  logic                      first_beat, is_last;
  logic [7:0]                beats_left;
  logic [AXI_ADDR_WIDTH-1:0] end_addr;
  logic                      cmd_hs, burst_hs, beat_hs, w_last, zero_done, xfer_end, done_src;
  logic [STRB_WIDTH-1:0]     strb;
  logic                      unused_addr_hi;

  assign end_addr       = i_cmd_address + AXI_ADDR_WIDTH'(i_cmd_length) - AXI_ADDR_WIDTH'(1);
  assign unused_addr_hi = ^end_addr[AXI_ADDR_WIDTH-1:OFFSET_WIDTH];
  assign cmd_hs         = i_cmd_valid && o_cmd_ready;
  assign burst_hs       = i_burst_valid && o_burst_ready;
  assign w_last         = (beats_left == 8'd0);
  assign strb           = STRB_WIDTH'(strb_mask(STRB_WIDTH, int'(first_off), int'(last_off),
                                                first_beat, is_last && w_last));

  always_comb begin
    state_nxt     = state;
    o_cmd_ready   = 1'b0;
    o_burst_ready = 1'b0;
    zero_done     = 1'b0;
    xfer_end      = 1'b0;
    case (state)
      IDLE: begin
        o_cmd_ready = 1'b1;
        if (i_cmd_valid) begin
          if (i_cmd_length == '0) zero_done = 1'b1;
          else                    state_nxt = WAIT_BURST;
        end
      end
      WAIT_BURST: begin
        o_burst_ready = 1'b1;
        if (i_burst_valid) state_nxt = DATA;
      end
      DATA: begin
        if (beat_hs && w_last) begin
          state_nxt = is_last ? IDLE : WAIT_BURST;
          xfer_end  = is_last;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef PRISM_AXI_WDATA_SKID_EN
  logic skid_in_ready, out_done;

  // The done tag travels with the final beat so o_done lines up with its W handshake.
  assign s_ready  = (state == DATA) && skid_in_ready;
  assign beat_hs  = s_valid && s_ready;
  assign done_src = m_wvalid && m_wready && out_done;

  prism_axi_skid_buffer #(.WIDTH(AXI_DATA_WIDTH + STRB_WIDTH + 2)) u_skid (
    .clock     (clock),
    .resetn    (resetn),
    .in_valid  (s_valid && (state == DATA)),
    .in_ready  (skid_in_ready),
    .in_data   ({s_data, strb, w_last, w_last && is_last}),
    .out_valid (m_wvalid),
    .out_ready (m_wready),
    .out_data  ({m_wdata, m_wstrb, m_wlast, out_done})
  );
`else
  assign m_wvalid = (state == DATA) && s_valid;
  assign s_ready  = (state == DATA) && m_wready;
  assign m_wdata  = s_data;
  assign m_wstrb  = strb;
  assign m_wlast  = w_last;
  assign beat_hs  = m_wvalid && m_wready;
  assign done_src = xfer_end;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      first_off  <= '0;
      last_off   <= '0;
      first_beat <= 1'b0;
      is_last    <= 1'b0;
      beats_left <= '0;
      o_done     <= 1'b0;
    end else begin
      state  <= state_nxt;
      o_done <= zero_done || done_src;
      if (cmd_hs) begin
        first_off  <= i_cmd_address[OFFSET_WIDTH-1:0];
        last_off   <= end_addr[OFFSET_WIDTH-1:0];
        first_beat <= 1'b1;
      end
      if (burst_hs) begin
        beats_left <= i_burst_axlen;
        is_last    <= i_burst_is_last;
      end
      if (beat_hs) begin
        first_beat <= 1'b0;
        if (!w_last) beats_left <= beats_left - 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_prism_axi_wdata_ctrl.sv
// Scoreboard bench for prism_axi_wdata_ctrl: byte-range reference model, random stalls, reset mid-burst.
module tb_prism_axi_wdata_ctrl;
  localparam int AW = 32, DW = 64, LW = 16, SW = DW / 8;

  logic          clock = 1'b0, resetn = 1'b0;
  logic          i_cmd_valid = 1'b0, o_cmd_ready;
  logic [AW-1:0] i_cmd_address = '0;
  logic [LW-1:0] i_cmd_length = '0;
  logic          i_burst_valid = 1'b0, o_burst_ready, i_burst_is_last = 1'b0;
  logic [7:0]    i_burst_axlen = '0;
  logic [DW-1:0] s_data = '0, m_wdata;
  logic          s_valid = 1'b0, s_ready;
  logic [SW-1:0] m_wstrb;
  logic          m_wlast, m_wvalid, m_wready = 1'b1, o_done;

  always #5 clock = ~clock;

  prism_axi_wdata_ctrl #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .LENGTH_WIDTH(LW)) dut (
    .clock(clock), .resetn(resetn),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_address(i_cmd_address), .i_cmd_length(i_cmd_length),
    .i_burst_valid(i_burst_valid), .o_burst_ready(o_burst_ready),
    .i_burst_axlen(i_burst_axlen), .i_burst_is_last(i_burst_is_last),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
    .m_wready(m_wready), .o_done(o_done)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic          last;
  } beat_t;

  beat_t         exp_q[$];
  logic [DW-1:0] data_q[$];
  int            d_len[$];
  int            n_chk = 0, n_fail = 0, done_cnt = 0, beat_cnt = 0;
  bit            stall = 0, abort = 0, burst_rdy_seen = 0, prev_stall = 0;
  beat_t         prev, e_mon;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: actual timeout required handshake", name);
  endtask

  always begin
    @(posedge clock);
    #1;
    m_wready = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  // Monitor: pops the expected beat on every W handshake and checks stall stability.
  always @(negedge clock) begin
    if (!resetn) prev_stall = 0;
    else begin
      if (o_burst_ready) burst_rdy_seen = 1;
      if (o_done) done_cnt++;
      if (prev_stall)
        check("w_stable", 128'({m_wvalid, m_wdata, m_wstrb, m_wlast}), 128'({1'b1, prev}));
      if (m_wvalid && m_wready) begin
        if (exp_q.size() == 0) check("w_unexpected", 128'(m_wdata), 128'(0));
        else begin
          e_mon = exp_q.pop_front();
          check("wdata", 128'(m_wdata), 128'(e_mon.data));
          check("wstrb", 128'(m_wstrb), 128'(e_mon.strb));
          check("wlast", 128'(m_wlast), 128'(e_mon.last));
        end
        beat_cnt++;
      end
      prev_stall = m_wvalid && !m_wready;
      prev       = {m_wdata, m_wstrb, m_wlast};
    end
  end

  task automatic send_cmd(input logic [AW-1:0] addr, input int len);
    bit hs = 0;
    i_cmd_address = addr;
    i_cmd_length  = LW'(len);
    i_cmd_valid   = 1'b1;
    for (int c = 0; c < 5000 && !hs && !abort; c++) begin
      @(negedge clock);
      hs = i_cmd_valid && o_cmd_ready;
      @(posedge clock);
      #1;
    end
    i_cmd_valid = 1'b0;
    if (!hs && !abort) timeout("cmd_handshake");
  endtask

  task automatic send_descs();
    foreach (d_len[b]) begin
      bit hs = 0;
      i_burst_axlen   = 8'(d_len[b]);
      i_burst_is_last = (b == d_len.size() - 1);
      i_burst_valid   = 1'b1;
      for (int c = 0; c < 5000 && !hs && !abort; c++) begin
        @(negedge clock);
        hs = i_burst_valid && o_burst_ready;
        @(posedge clock);
        #1;
      end
      i_burst_valid = 1'b0;
      if (abort) break;
      if (!hs) begin
        timeout("burst_handshake");
        break;
      end
    end
  endtask

  task automatic drive_data(input int n);
    int k = 0, budget = 0;
    bit hs;
    s_valid = 1'b0;
    while (k < n) begin
      @(negedge clock);
      hs = s_valid && s_ready;
      @(posedge clock);
      #1;
      if (abort) break;
      if (hs) begin
        k++;
        s_valid = 1'b0;
      end
      if (k < n && !s_valid) begin
        s_data  = data_q[k];
        s_valid = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
      end
      if (++budget > 20000) begin
        timeout("data_stream");
        break;
      end
    end
    s_valid = 1'b0;
  endtask

  // Reference model: a beat's byte is enabled iff its address falls in [addr, addr+len).
  task automatic run_xfer(input logic [AW-1:0] addr, input int len);
    logic [AW-1:0] base, ba, a;
    beat_t e;
    int g, d0;
    g  = 0;
    d0 = done_cnt;
    base = addr & ~AW'(SW - 1);
    data_q.delete();
    foreach (d_len[b])
      for (int j = 0; j <= d_len[b]; j++) begin
        e.data = {$urandom, $urandom};
        ba = base + AW'(g * SW);
        for (int i = 0; i < SW; i++) begin
          a = ba + AW'(i);
          e.strb[i] = (a - addr) < AW'(len);
        end
        e.last = (j == d_len[b]);
        exp_q.push_back(e);
        data_q.push_back(e.data);
        g++;
      end
    fork
      send_cmd(addr, len);
      send_descs();
      drive_data(g);
    join
    if (!abort) begin
      repeat (4) @(posedge clock);
      #1;
      check("beats_drained", 128'(exp_q.size()), 128'(0));
      check("done_pulses", 128'(done_cnt - d0), 128'(1));
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_cmd_ready"}, 128'(o_cmd_ready), 128'(1));
    check({tag, "_burst_ready"}, 128'(o_burst_ready), 128'(0));
    check({tag, "_s_ready"}, 128'(s_ready), 128'(0));
    check({tag, "_wvalid"}, 128'(m_wvalid), 128'(0));
    check({tag, "_done"}, 128'(o_done), 128'(0));
  endtask

  initial begin
    logic [AW-1:0] ra;
    int rl, nb, b0, sz;
    #2;
    check_idle("rst_held");
    repeat (3) @(posedge clock);
    #1;
    resetn = 1'b1;
    #1;
    check_idle("rst_released");
    @(posedge clock);
    #1;

    d_len = '{1};      run_xfer(32'h1003, 10);
    d_len = '{0};      run_xfer(32'h1005, 2);
    d_len = '{255, 255}; run_xfer(32'h0, 4096);
    d_len = '{1};      run_xfer(32'hFFFF_FFFD, 6);

    // Zero-length command: immediate done, no descriptor, no beat.
    burst_rdy_seen = 0;
    b0 = done_cnt;
    send_cmd(32'h2000, 0);
    check("len0_done_next", 128'(o_done), 128'(1));
    repeat (4) @(posedge clock);
    #1;
    check("len0_burst_ready", 128'(burst_rdy_seen), 128'(0));
    check("len0_done_count", 128'(done_cnt - b0), 128'(1));
    check("len0_idle", 128'(o_cmd_ready), 128'(1));

    stall = 1;
    d_len = '{255, 255}; run_xfer(32'h0, 4096);
    for (int t = 0; t < 6; t++) begin
      ra = $urandom;
      rl = $urandom_range(1, 300);
      nb = (int'(ra[2:0]) + rl - 1) / SW + 1;
      d_len.delete();
      while (nb > 0) begin
        sz = $urandom_range(1, nb < 16 ? nb : 16);
        d_len.push_back(sz - 1);
        nb -= sz;
      end
      run_xfer(ra, rl);
    end
    stall = 0;

    // Reset in the middle of beat 100 of a long transfer.
    b0 = beat_cnt;
    d_len = '{255, 255};
    fork
      run_xfer(32'h0, 4096);
      begin
        for (int c = 0; c < 3000 && beat_cnt < b0 + 100; c++) @(posedge clock);
        if (beat_cnt < b0 + 100) timeout("reach_beat_100");
        @(posedge clock);
        #3;
        check("pre_rst_wvalid", 128'(m_wvalid), 128'(1));
        abort  = 1;
        resetn = 1'b0;
        #1;
        check("rst_async_wvalid", 128'(m_wvalid), 128'(0));
      end
    join
    exp_q.delete();
    repeat (2) @(posedge clock);
    #1;
    check_idle("mid_rst");
    abort  = 0;
    resetn = 1'b1;
    #1;
    check_idle("post_rst");
    @(posedge clock);
    #1;
    d_len = '{1}; run_xfer(32'h1003, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
